rr_out_aggr_sched: RTL and testbench

Packet-level scheduler for the round-robin outport aggregator. It merges four first-word-fall-through input FIFOs onto one NetFPGA output bus (data/ctrl/wr/rdy) and switches only on packet boundaries. It runs in round-robin mode or in fixed-port mode, where the port comes from the register block's `outport_sel`. It exports `state` and `eop` to that register block for status and packet counting.

---
 rtl/rr_out_aggr_sched.sv | 117 +++++++++++
 tb/tb_rr_out_aggr_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_out_aggr_sched.sv
// rtl/rr_out_aggr_sched.sv - packet-boundary round-robin / fixed-port scheduler for four FWFT queues
module rr_out_aggr_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*DATA_WIDTH-1:0] in_fifo_data,
  input  logic [4*CTRL_WIDTH-1:0] in_fifo_ctrl,
  input  logic [3:0]              in_fifo_empty,
  output logic [3:0]              in_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CTRL_WIDTH-1:0]   out_ctrl,
  output logic                    out_wr,
  input  logic                    out_rdy,
  input  logic                    rr_mode,
  input  logic [1:0]              outport_sel,
  output logic                    state,
  output logic                    eop,
  output logic [1:0]              cur_port
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  st, st_nxt;
  logic [1:0]              port_nxt;
  logic                    seen_data, seen_nxt;
  logic [DATA_WIDTH-1:0]   data_q [4];
  logic [CTRL_WIDTH-1:0]   ctrl_q [4];
  logic [DATA_WIDTH-1:0]   head_data;
  logic [CTRL_WIDTH-1:0]   head_ctrl;
  logic                    pop;
  logic                    pkt_end;
  logic                    grant_ok;
  logic [1:0]              winner;
  logic [1:0]              cand;

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign data_q[i] = in_fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign ctrl_q[i] = in_fifo_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
  end

  assign head_data = data_q[cur_port];
  assign head_ctrl = ctrl_q[cur_port];
  assign pop       = (st == SEND) && !in_fifo_empty[cur_port] && out_rdy;
  // End of packet: first nonzero ctrl after a data word of this packet
  assign pkt_end   = pop && (head_ctrl != '0) && seen_data;
  assign state     = (st == SEND);

  // Search order cur_port+1 .. cur_port+4, so the current port is tried last
  always_comb begin
    grant_ok = 1'b0;
    winner   = cur_port;
    cand     = cur_port;
    if (rr_mode) begin
      for (int k = 1; k <= 4; k++) begin
        cand = cur_port + 2'(k);
        if (!grant_ok && !in_fifo_empty[cand]) begin
          grant_ok = 1'b1;
          winner   = cand;
        end
      end
    end else if (!in_fifo_empty[outport_sel]) begin
      grant_ok = 1'b1;
      winner   = outport_sel;
    end
  end

  always_comb begin
    st_nxt        = st;
    port_nxt      = cur_port;
    seen_nxt      = seen_data;
    in_fifo_rd_en = 4'b0000;
    case (st)
      IDLE: begin
        if (grant_ok) begin
          st_nxt   = SEND;
          port_nxt = winner;
          seen_nxt = 1'b0;
        end
      end
      SEND: begin
        if (pop) begin
          in_fifo_rd_en[cur_port] = 1'b1;
          if (head_ctrl == '0)
            seen_nxt = 1'b1;
          if (pkt_end)
            st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      cur_port  <= 2'd3;
      seen_data <= 1'b0;
      out_wr    <= 1'b0;
      eop       <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else begin
      st        <= st_nxt;
      cur_port  <= port_nxt;
      seen_data <= seen_nxt;
      out_wr    <= pop;
      eop       <= pkt_end;
      if (pop) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_rr_out_aggr_sched.sv
// tb/tb_rr_out_aggr_sched.sv - directed self-checking bench for rr_out_aggr_sched
module tb_rr_out_aggr_sched;
  localparam int DW = 64;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [4*DW-1:0] in_fifo_data;
  logic [4*CW-1:0] in_fifo_ctrl;
  logic [3:0]      in_fifo_empty;
  logic [3:0]      in_fifo_rd_en;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic            out_wr;
  logic            out_rdy;
  logic            rr_mode;
  logic [1:0]      outport_sel;
  logic            state;
  logic            eop;
  logic [1:0]      cur_port;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] qd [4][256];
  logic [7:0]  qc [4][256];
  int          wr_p [4] = '{0, 0, 0, 0};
  int          rd_p [4] = '{0, 0, 0, 0};
  logic [3:0]  hold = 4'b0000;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        e;
    int          cy;
  } ent_t;
  ent_t wlog[$];

  rr_out_aggr_sched #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_fifo_data(in_fifo_data), .in_fifo_ctrl(in_fifo_ctrl),
    .in_fifo_empty(in_fifo_empty), .in_fifo_rd_en(in_fifo_rd_en),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .rr_mode(rr_mode), .outport_sel(outport_sel),
    .state(state), .eop(eop), .cur_port(cur_port)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FWFT queue models
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_fifo_data[i*DW +: DW] = qd[i][rd_p[i] % 256];
      in_fifo_ctrl[i*CW +: CW] = qc[i][rd_p[i] % 256];
      in_fifo_empty[i]         = (rd_p[i] == wr_p[i]) || hold[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (in_fifo_rd_en[i]) rd_p[i] <= rd_p[i] + 1;
  end

  always @(negedge clk) begin
    if (out_wr) wlog.push_back('{d: out_data, c: out_ctrl, e: eop, cy: cyc});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops must target a non-empty queue and be one-hot
  always @(negedge clk) begin
    #2;
    if (!reset)
      chk("rd_en_legal",
          64'(((in_fifo_rd_en & in_fifo_empty) == 4'b0) && ($countones(in_fifo_rd_en) <= 1)), 64'd1);
  end

  function automatic logic [63:0] mk(input int q, input int tag, input int w);
    return {8'(q), 8'(tag), 16'(w), 32'hC0DE_0000 | 32'(w)};
  endfunction

  function automatic logic [7:0] ctl(input int w, input int n);
    return (w == 0) ? 8'hFF : (w == n - 1) ? 8'h01 : 8'h00;
  endfunction

  task automatic push_pkt(input int q, input int tag, input int n);
    for (int w = 0; w < n; w++) begin
      qd[q][wr_p[q] % 256] = mk(q, tag, w);
      qc[q][wr_p[q] % 256] = ctl(w, n);
      wr_p[q] = wr_p[q] + 1;
    end
  endtask

  task automatic wait_quiet(input string tag, input int maxc);
    int q = 0;
    int n = 0;
    while (q < 3 && n < maxc) begin
      @(negedge clk);
      n++;
      if (!state && !out_wr) q++;
      else q = 0;
    end
    chk(tag, 64'(q == 3), 64'd1);
  endtask

  // Compare a run of n logged words starting at index base against packet (q, tag)
  task automatic chk_pkt(input string tag, input int base, input int q, input int ptag, input int n);
    for (int w = 0; w < n; w++) begin
      if (base + w < wlog.size()) begin
        chk({tag, "_data"}, wlog[base+w].d, mk(q, ptag, w));
        chk({tag, "_ctrl"}, 64'(wlog[base+w].c), 64'(ctl(w, n)));
        chk({tag, "_eop"},  64'(wlog[base+w].e), 64'(w == n - 1));
      end else begin
        chk({tag, "_missing"}, 64'(base + w), 64'(wlog.size()));
      end
    end
  endtask

  function automatic int eop_count();
    int c = 0;
    foreach (wlog[i]) if (wlog[i].e) c++;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; out_rdy = 1'b1; rr_mode = 1'b1; outport_sel = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cur_port", 64'(cur_port), 64'd3);
    chk("rst_out_wr", 64'({out_wr, eop}), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_rd_en", 64'(in_fifo_rd_en), 64'd0);
    reset = 1'b0;

    // Single 3-word packet on queue 2, cycle-by-cycle
    @(negedge clk);
    push_pkt(2, 1, 3);
    #1;
    chk("t1_idle_state", 64'(state), 64'd0);
    chk("t1_idle_rd_en", 64'(in_fifo_rd_en), 64'd0);
    @(negedge clk);
    chk("t1_grant_state", 64'(state), 64'd1);
    chk("t1_grant_port", 64'(cur_port), 64'd2);
    chk("t1_grant_rd_en", 64'(in_fifo_rd_en), 64'b0100);
    chk("t1_grant_wr", 64'(out_wr), 64'd0);
    @(negedge clk);
    chk("t1_w0_wr", 64'({out_wr, eop}), 64'b10);
    chk("t1_w0_data", out_data, mk(2, 1, 0));
    chk("t1_w0_ctrl", 64'(out_ctrl), 64'hFF);
    @(negedge clk);
    chk("t1_w1_wr", 64'({out_wr, eop, state}), 64'b101);
    chk("t1_w1_data", out_data, mk(2, 1, 1));
    @(negedge clk);
    chk("t1_w2_wr", 64'({out_wr, eop, state}), 64'b110);
    chk("t1_w2_data", out_data, mk(2, 1, 2));
    chk("t1_w2_ctrl", 64'(out_ctrl), 64'h01);
    @(negedge clk);
    chk("t1_after", 64'({out_wr, eop, state}), 64'b000);
    chk("t1_after_port", 64'(cur_port), 64'd2);
    chk("t1_hold_data", out_data, mk(2, 1, 2));

    // Round-robin over four queues, two packets each
    reset = 1'b1;
    #1;
    chk("t2_rst_port", 64'(cur_port), 64'd3);
    @(negedge clk);
    reset = 1'b0;
    wlog.delete();
    for (int q = 0; q < 4; q++) begin
      push_pkt(q, 0, 4);
      push_pkt(q, 1, 4);
    end
    wait_quiet("t2_quiet", 400);
    chk("t2_count", 64'(wlog.size()), 64'd32);
    chk("t2_eops", 64'(eop_count()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk_pkt("t2_pkt", k * 4, k % 4, k / 4, 4);
      if (k > 0 && wlog.size() >= 32)
        chk("t2_gap", 64'(wlog[k*4].cy - wlog[k*4-1].cy), 64'd2);
    end

    // Fixed port 1, then switch to port 0 mid-packet
    wlog.delete();
    rr_mode = 1'b0; outport_sel = 2'd1;
    push_pkt(0, 2, 4);
    push_pkt(1, 2, 6);
    push_pkt(1, 3, 6);
    repeat (3) @(negedge clk);
    chk("t3_mid_port", 64'(cur_port), 64'd1);
    outport_sel = 2'd0;
    wait_quiet("t3_quiet", 200);
    chk("t3_count", 64'(wlog.size()), 64'd10);
    chk_pkt("t3_q1", 0, 1, 2, 6);
    chk_pkt("t3_q0", 6, 0, 2, 4);
    chk("t3_q1_pending", 64'(in_fifo_empty[1]), 64'd0);
    chk("t3_port", 64'(cur_port), 64'd0);
    rr_mode = 1'b1;
    wait_quiet("t3_drain", 200);
    chk("t3_total", 64'(wlog.size()), 64'd16);
    chk_pkt("t3_q1b", 10, 1, 3, 6);

    // out_rdy toggling during a 10-word packet
    wlog.delete();
    push_pkt(2, 4, 10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("t4_rdy_gate", 64'(out_wr && !out_rdy), 64'd0);
      out_rdy = ~out_rdy;
    end
    out_rdy = 1'b1;
    wait_quiet("t4_quiet", 200);
    chk("t4_count", 64'(wlog.size()), 64'd10);
    chk_pkt("t4_pkt", 0, 2, 4, 10);

    // Queue 3 stalls mid-packet while queue 0 waits
    wlog.delete();
    push_pkt(3, 5, 8);
    push_pkt(0, 5, 4);
    repeat (4) @(negedge clk);
    hold[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall", 64'({state, cur_port, in_fifo_rd_en}), {57'd0, 1'b1, 2'd3, 4'b0000});
      if (i > 0) chk("t5_stall_wr", 64'(out_wr), 64'd0);
    end
    hold[3] = 1'b0;
    wait_quiet("t5_quiet", 200);
    chk("t5_count", 64'(wlog.size()), 64'd12);
    chk_pkt("t5_q3", 0, 3, 5, 8);
    chk_pkt("t5_q0", 8, 0, 5, 4);

    // Reset mid-packet on queue 2
    wlog.delete();
    push_pkt(2, 6, 6);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_out", 64'({out_wr, eop, state}), 64'd0);
    chk("t6_rst_rd_en", 64'(in_fifo_rd_en), 64'd0);
    chk("t6_rst_port", 64'(cur_port), 64'd3);
    push_pkt(3, 6, 4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_regrant", 64'({state, cur_port}), {61'd0, 1'b1, 2'd2});
    wait_quiet("t6_quiet", 200);
    chk("t6_count", 64'(wlog.size()), 64'd10);
    chk("t6_eops", 64'(eop_count()), 64'd2);
    if (wlog.size() >= 10) begin
      chk("t6_resume", wlog[3].d, mk(2, 6, 3));
      chk("t6_q3_first", wlog[6].d, mk(3, 6, 0));
    end else begin
      chk("t6_short_log", 64'(wlog.size()), 64'd10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
